// File: rtl/dcache_controller.sv
// dcache_controller: write-back, write-allocate data-cache controller.
// Sits between the CPU load/store port, a 2-way tag/data SRAM (dcache_sram)
// and a 256-bit line memory. Hits finish combinationally; misses stall the
// CPU while the FSM writes back a dirty victim, refills the line and then
// replays the access as a hit.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cpu_req_i/cpu_write_i        CPU access request / store select
//   cpu_addr_i/cpu_data_i        CPU byte address (word aligned) / store data
//   cpu_data_o/cpu_stall_o       load data / stall while the access is pending
//   mem_enable_o/mem_write_o     line memory request / write-back select
//   mem_addr_o/mem_data_o        line address / write-back line (registered)
//   mem_data_i/mem_ack_i         refill line / one-cycle completion pulse
//   sram_addr_o/sram_tag_o       SRAM set index / tag word {valid,dirty,tag}
//   sram_data_o/sram_enable_o    SRAM write line / SRAM access enable
//   sram_write_o                 SRAM write strobe
//   sram_tag_i/sram_data_i       tag and line of the hit way (LRU way on miss)
//   sram_hit_i                   SRAM hit indication
module dcache_controller #(
   parameter  int unsigned TAG_W  = 23,
   parameter  int unsigned IDX_W  = 4,
   parameter  int unsigned OFS_W  = 5,
   localparam int unsigned LINE_W = 8 << OFS_W,
   localparam int unsigned WORD_W = 32,
   localparam int unsigned TWRD_W = TAG_W + 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_write_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   output logic              cpu_stall_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic [IDX_W-1:0]  sram_addr_o,
   output logic [TWRD_W-1:0] sram_tag_o,
   output logic [LINE_W-1:0] sram_data_o,
   output logic              sram_enable_o,
   output logic              sram_write_o,
   input  logic [TWRD_W-1:0] sram_tag_i,
   input  logic [LINE_W-1:0] sram_data_i,
   input  logic              sram_hit_i
);

   localparam int unsigned WSEL_W = OFS_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   state_t              state_q, state_d;
   logic                mem_enable_d, mem_write_d;
   logic [31:0]         mem_addr_d;
   logic [LINE_W-1:0]   mem_data_d;

   logic [TAG_W-1:0]    cpu_tag;
   logic [IDX_W-1:0]    cpu_idx;
   logic [WSEL_W-1:0]   cpu_word;
   logic [31:0]         refill_addr;
   logic [31:0]         victim_addr;
   logic                victim_dirty;
   logic [LINE_W-1:0]   store_line;
   logic                unused_addr_bits;

   // Address fields
   assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
   assign cpu_idx          = cpu_addr_i[OFS_W +: IDX_W];
   assign cpu_word         = cpu_addr_i[2 +: WSEL_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign refill_addr  = {cpu_tag, cpu_idx, {OFS_W{1'b0}}};
   assign victim_addr  = {sram_tag_i[TAG_W-1:0], cpu_idx, {OFS_W{1'b0}}};
   assign victim_dirty = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];

   // CPU side: word select, and a stall whenever the access is not a hit in IDLE
   assign cpu_data_o    = sram_data_i[{cpu_word, 5'd0} +: WORD_W];
   assign cpu_stall_o   = cpu_req_i & ~((state_q == IDLE) & sram_hit_i);
   assign sram_addr_o   = cpu_idx;
   assign sram_enable_o = cpu_req_i;

   // Store merge: current line with the addressed word replaced
   always_comb begin
      store_line = sram_data_i;
      store_line[{cpu_word, 5'd0} +: WORD_W] = cpu_data_i;
   end

   // State and memory-request registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
      end else begin
         state_q      <= state_d;
         mem_enable_o <= mem_enable_d;
         mem_write_o  <= mem_write_d;
         mem_addr_o   <= mem_addr_d;
         mem_data_o   <= mem_data_d;
      end
   end

   // Next state, memory request updates and SRAM write port
   always_comb begin
      state_d      = state_q;
      mem_enable_d = mem_enable_o;
      mem_write_d  = mem_write_o;
      mem_addr_d   = mem_addr_o;
      mem_data_d   = mem_data_o;
      sram_write_o = 1'b0;
      sram_data_o  = sram_data_i;
      sram_tag_o   = {1'b1, 1'b0, cpu_tag};

      unique case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               if (sram_hit_i) begin
                  if (cpu_write_i) begin
                     sram_write_o = 1'b1;
                     sram_data_o  = store_line;
                     sram_tag_o   = {1'b1, 1'b1, cpu_tag};
                  end
               end else begin
                  state_d = MISS;
               end
            end
         end
         MISS: begin
            // Victim line is captured even when clean; only a dirty one is sent
            mem_data_d   = sram_data_i;
            mem_enable_d = 1'b1;
            if (victim_dirty) begin
               mem_addr_d  = victim_addr;
               mem_write_d = 1'b1;
               state_d     = WRITEBACK;
            end else begin
               mem_addr_d  = refill_addr;
               mem_write_d = 1'b0;
               state_d     = READMISS;
            end
         end
         WRITEBACK: begin
            // Request stays up and turns into the refill read
            if (mem_ack_i) begin
               mem_addr_d  = refill_addr;
               mem_write_d = 1'b0;
               state_d     = READMISS;
            end
         end
         READMISS: begin
            if (mem_ack_i) begin
               sram_write_o = 1'b1;
               sram_data_o  = mem_data_i;
               sram_tag_o   = {1'b1, 1'b0, cpu_tag};
               mem_enable_d = 1'b0;
               state_d      = READMISSOK;
            end
         end
         READMISSOK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
